// File: rtl/wrap_dec_8b_10b_if.sv
// -----------------------------------------------------------------------------
// wrap_dec_8b_10b_if
// Flit bus between the PHY deserializer (master) and the 8b/10b unwrapper
// (slave). The 2-bit select fields carry the comma_length_sel_t and
// comma_sel_t encodings from wrap_dec_8b_10b_pkg.
//
// Signals
//   valid_in, flit_in, comma_length_sel_in, clr_err     master -> slave
//   valid_out, flit_out, comma_sel_out, meta_out,
//   pkt_active, code_err, frame_err, err_count          slave  -> master
// -----------------------------------------------------------------------------
interface wrap_dec_8b_10b_if #(
  parameter int PORTCOUNT = 5,
  parameter int ERR_CNT_W = 8
);
  logic                    valid_in;
  logic [PORTCOUNT*10-1:0] flit_in;
  logic [1:0]              comma_length_sel_in;
  logic                    clr_err;

  logic                    valid_out;
  logic [PORTCOUNT*8-1:0]  flit_out;
  logic [1:0]              comma_sel_out;
  logic [7:0]              meta_out;
  logic                    pkt_active;
  logic                    code_err;
  logic                    frame_err;
  logic [ERR_CNT_W-1:0]    err_count;

  modport master (
    output valid_in, flit_in, comma_length_sel_in, clr_err,
    input  valid_out, flit_out, comma_sel_out, meta_out,
           pkt_active, code_err, frame_err, err_count
  );

  modport slave (
    input  valid_in, flit_in, comma_length_sel_in, clr_err,
    output valid_out, flit_out, comma_sel_out, meta_out,
           pkt_active, code_err, frame_err, err_count
  );
endinterface

// File: rtl/wrap_dec_8b_10b.sv
// -----------------------------------------------------------------------------
// wrap_dec_8b_10b
// Receive-side 8b/10b unwrapper. Each accepted flit holds PORTCOUNT 10-bit
// symbols. The flit is classified as a framing comma, a resend/ack comma or a
// data flit. Data lanes are decoded back to bytes. A two-state FSM tracks
// packet framing, and coding and framing errors are flagged and counted.
//
// Symbol bit order: sym[9:4] = abcdei (6b group), sym[3:0] = fghj (4b group).
// Decoded byte = {HGF, EDCBA}.
//
// Ports
//   CLK                       rising-edge clock
//   nRST                      asynchronous active-low reset
//   bus (slave)               valid_in, flit_in, comma_length_sel_in, clr_err
//                             in; valid_out, flit_out, comma_sel_out, meta_out,
//                             pkt_active, code_err, frame_err, err_count out
// -----------------------------------------------------------------------------
package wrap_dec_8b_10b_pkg;

  typedef enum logic [1:0] {
    SELECT_COMMA_1_FLIT = 2'd0,
    SELECT_COMMA_2_FLIT = 2'd1,
    SELECT_COMMA_DATA   = 2'd2
  } comma_length_sel_t;

  typedef enum logic [1:0] {
    START_PACKET_SEL   = 2'd0,
    END_PACKET_SEL     = 2'd1,
    RESEND_PACKET0_SEL = 2'd2,
    DATA_SEL           = 2'd3
  } comma_sel_t;

  // K28.5 and K28.1 in the RD- column. Neither is a legal data code, so a
  // comma can never be mistaken for a data byte.
  localparam logic [9:0] START_COMMA          = 10'b001111_1010;
  localparam logic [9:0] RESEND_PACKET0_COMMA = 10'b001111_1001;

endpackage

module wrap_dec_8b_10b
  import wrap_dec_8b_10b_pkg::*;
#(
  parameter int PORTCOUNT = 5,
  parameter int ERR_CNT_W = 8
) (
  input  logic           CLK,
  input  logic           nRST,
  wrap_dec_8b_10b_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  // Returns {err, edcba}. Both running-disparity columns are accepted,
  // because no disparity state is carried across flits.
  function automatic logic [5:0] dec_6b5b(input logic [5:0] c);
    logic [5:0] r;
    case (c)
      6'b100111, 6'b011000: r = {1'b0, 5'd0};
      6'b011101, 6'b100010: r = {1'b0, 5'd1};
      6'b101101, 6'b010010: r = {1'b0, 5'd2};
      6'b110001:            r = {1'b0, 5'd3};
      6'b110101, 6'b001010: r = {1'b0, 5'd4};
      6'b101001:            r = {1'b0, 5'd5};
      6'b011001:            r = {1'b0, 5'd6};
      6'b111000, 6'b000111: r = {1'b0, 5'd7};
      6'b111001, 6'b000110: r = {1'b0, 5'd8};
      6'b100101:            r = {1'b0, 5'd9};
      6'b010101:            r = {1'b0, 5'd10};
      6'b110100:            r = {1'b0, 5'd11};
      6'b001101:            r = {1'b0, 5'd12};
      6'b101100:            r = {1'b0, 5'd13};
      6'b011100:            r = {1'b0, 5'd14};
      6'b010111, 6'b101000: r = {1'b0, 5'd15};
      6'b011011, 6'b100100: r = {1'b0, 5'd16};
      6'b100011:            r = {1'b0, 5'd17};
      6'b010011:            r = {1'b0, 5'd18};
      6'b110010:            r = {1'b0, 5'd19};
      6'b001011:            r = {1'b0, 5'd20};
      6'b101010:            r = {1'b0, 5'd21};
      6'b011010:            r = {1'b0, 5'd22};
      6'b111010, 6'b000101: r = {1'b0, 5'd23};
      6'b110011, 6'b001100: r = {1'b0, 5'd24};
      6'b100110:            r = {1'b0, 5'd25};
      6'b010110:            r = {1'b0, 5'd26};
      6'b110110, 6'b001001: r = {1'b0, 5'd27};
      6'b001110:            r = {1'b0, 5'd28};
      6'b101110, 6'b010001: r = {1'b0, 5'd29};
      6'b011110, 6'b100001: r = {1'b0, 5'd30};
      6'b101011, 6'b010100: r = {1'b0, 5'd31};
      default:              r = {1'b1, 5'd0};
    endcase
    return r;
  endfunction

  // Returns {err, hgf}. Both the primary and the alternate D.x.7 forms are
  // accepted.
  function automatic logic [3:0] dec_4b3b(input logic [3:0] c);
    logic [3:0] r;
    case (c)
      4'b1011, 4'b0100: r = {1'b0, 3'd0};
      4'b1001:          r = {1'b0, 3'd1};
      4'b0101:          r = {1'b0, 3'd2};
      4'b1100, 4'b0011: r = {1'b0, 3'd3};
      4'b1101, 4'b0010: r = {1'b0, 3'd4};
      4'b1010:          r = {1'b0, 3'd5};
      4'b0110:          r = {1'b0, 3'd6};
      4'b1110, 4'b0001,
      4'b0111, 4'b1000: r = {1'b0, 3'd7};
      default:          r = {1'b1, 3'd0};
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Per-lane combinational decode
  // ---------------------------------------------------------------------------
  logic [PORTCOUNT*8-1:0] dec_flit;
  logic [PORTCOUNT-1:0]   lane_err;

  for (genvar g = 0; g < PORTCOUNT; g++) begin : g_lane
    logic [5:0] r6;
    logic [3:0] r4;
    assign r6 = dec_6b5b(bus.flit_in[g*10+4 +: 6]);
    assign r4 = dec_4b3b(bus.flit_in[g*10 +: 4]);
    assign dec_flit[g*8 +: 8] = {r4[2:0], r6[4:0]};
    assign lane_err[g]        = r6[5] | r4[3];
  end

  // ---------------------------------------------------------------------------
  // Comma pattern recognition
  // ---------------------------------------------------------------------------
  logic [9:0] top_sym;
  logic       is_frame_comma;
  logic       is_resend_comma;

  assign top_sym         = bus.flit_in[PORTCOUNT*10-1 -: 10];
  assign is_frame_comma  = (top_sym == START_COMMA) &&
                           (&bus.flit_in[PORTCOUNT*10-11:0]);
  // The lane below the comma carries the meta byte. Only the lanes under it
  // must be filler.
  assign is_resend_comma = (top_sym == RESEND_PACKET0_COMMA) &&
                           (&bus.flit_in[(PORTCOUNT-2)*10-1:0]);

  // ---------------------------------------------------------------------------
  // FSM and output next-state
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  comma_length_sel_t len_sel;
  logic              valid_d, code_err_d, frame_err_d, ld_flit, ld_meta;
  comma_sel_t        sel_d;

  assign len_sel = comma_length_sel_t'(bus.comma_length_sel_in);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    valid_d     = 1'b0;
    code_err_d  = 1'b0;
    frame_err_d = 1'b0;
    ld_flit     = 1'b0;
    ld_meta     = 1'b0;
    sel_d       = DATA_SEL;

    if (bus.valid_in) begin
      case (len_sel)
        SELECT_COMMA_1_FLIT: begin
          if (is_frame_comma) begin
            valid_d = 1'b1;
            if (state_q == IDLE) begin
              sel_d   = START_PACKET_SEL;
              state_d = ACTIVE;
            end else begin
              sel_d   = END_PACKET_SEL;
              state_d = IDLE;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        SELECT_COMMA_2_FLIT: begin
          if (is_resend_comma) begin
            valid_d    = 1'b1;
            sel_d      = RESEND_PACKET0_SEL;
            ld_meta    = 1'b1;
            code_err_d = lane_err[PORTCOUNT-2];
          end else begin
            frame_err_d = 1'b1;
          end
        end
        SELECT_COMMA_DATA: begin
          code_err_d = |lane_err;
          if (state_q == ACTIVE) begin
            valid_d = 1'b1;
            sel_d   = DATA_SEL;
            ld_flit = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: frame_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: sequential state is always assigned with <=, so every flop
    // samples the values from before this edge.
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Saturating error counter
  // ---------------------------------------------------------------------------
  logic                 any_err;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign any_err = code_err_d | frame_err_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.clr_err)                           err_cnt_d = any_err ? CNT_ONE : '0;
    else if (any_err && err_cnt_q != CNT_MAX)  err_cnt_d = err_cnt_q + CNT_ONE;
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic                   valid_q, code_err_q, frame_err_q;
  logic [PORTCOUNT*8-1:0] flit_q;
  logic [7:0]             meta_q;
  comma_sel_t             sel_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q     <= 1'b0;
      code_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      flit_q      <= '0;
      meta_q      <= '0;
      sel_q       <= DATA_SEL;
      err_cnt_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      code_err_q  <= code_err_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
      if (ld_flit) flit_q <= dec_flit;
      if (ld_meta) meta_q <= dec_flit[(PORTCOUNT-2)*8 +: 8];
      if (valid_d) sel_q  <= sel_d;
    end
  end

  assign bus.valid_out     = valid_q;
  assign bus.flit_out      = flit_q;
  assign bus.comma_sel_out = sel_q;
  assign bus.meta_out      = meta_q;
  assign bus.pkt_active    = (state_q == ACTIVE);
  assign bus.code_err      = code_err_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.err_count     = err_cnt_q;

endmodule

// File: tb/tb_wrap_dec_8b_10b.sv
// -----------------------------------------------------------------------------
// tb_wrap_dec_8b_10b
// Directed testbench for wrap_dec_8b_10b. Flits are built by a local RD-
// 8b/10b encoder. Expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_wrap_dec_8b_10b;
  import wrap_dec_8b_10b_pkg::*;

  localparam int PC = 5;
  localparam int EW = 8;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  wrap_dec_8b_10b_if #(.PORTCOUNT(PC), .ERR_CNT_W(EW)) bus ();

  wrap_dec_8b_10b #(.PORTCOUNT(PC), .ERR_CNT_W(EW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // RD- encode tables: 5b/6b for D0..D31, 3b/4b for D.x.0..D.x.7
  logic [5:0] c6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [3:0] c4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                         4'b1101, 4'b1010, 4'b0110, 4'b1110};

  function automatic logic [9:0] enc8(input logic [7:0] b);
    return {c6[b[4:0]], c4[b[7:5]]};
  endfunction

  function automatic logic [PC*10-1:0] enc_flit(input logic [PC*8-1:0] d);
    logic [PC*10-1:0] f;
    for (int i = 0; i < PC; i++) f[i*10 +: 10] = enc8(d[i*8 +: 8]);
    return f;
  endfunction

  // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic [PC*10-1:0] f, input logic [1:0] sel,
                     input logic v, input logic clr);
    @(negedge CLK);
    bus.valid_in            = v;
    bus.flit_in             = f;
    bus.comma_length_sel_in = sel;
    bus.clr_err             = clr;
    @(posedge CLK);
    #1;
    bus.valid_in = 1'b0;
    bus.clr_err  = 1'b0;
  endtask

  task automatic send(input logic [PC*10-1:0] f, input logic [1:0] sel);
    cyc(f, sel, 1'b1, 1'b0);
  endtask

  logic [PC*10-1:0] start_flit, resend_flit, resend_bad, data_flit, rdp_flit, bad_flit;

  initial begin
    bus.valid_in            = 1'b0;
    bus.flit_in             = '0;
    bus.comma_length_sel_in = SELECT_COMMA_DATA;
    bus.clr_err             = 1'b0;

    start_flit  = {START_COMMA, {40{1'b1}}};
    resend_flit = {RESEND_PACKET0_COMMA, enc8(8'h03), {30{1'b1}}};
    resend_bad  = resend_flit;
    resend_bad[0] = 1'b0;
    rdp_flit    = enc_flit(40'h3CFF5AA500);
    rdp_flit[9:0] = 10'b011000_0100;            // D0.0 in its RD+ form
    bad_flit    = enc_flit(40'h1122334455);
    bad_flit[29:20] = 10'b0;                    // lane 2: not a legal code

    // ---- reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid",  bus.valid_out, 0);
    check("rst_flit",   bus.flit_out, 0);
    check("rst_sel",    bus.comma_sel_out, DATA_SEL);
    check("rst_meta",   bus.meta_out, 0);
    check("rst_pkt",    bus.pkt_active, 0);
    check("rst_cerr",   bus.code_err, 0);
    check("rst_ferr",   bus.frame_err, 0);
    check("rst_cnt",    bus.err_count, 0);
    @(negedge CLK);
    nRST = 1'b1;

    // ---- 1: START comma
    send(start_flit, SELECT_COMMA_1_FLIT);
    check("start_valid", bus.valid_out, 1);
    check("start_sel",   bus.comma_sel_out, START_PACKET_SEL);
    check("start_pkt",   bus.pkt_active, 1);

    // ---- 2: data, hold on idle, RD+ lane, then END
    send(enc_flit(40'h0123456789), SELECT_COMMA_DATA);
    check("data_valid", bus.valid_out, 1);
    check("data_flit",  bus.flit_out, 40'h0123456789);
    check("data_sel",   bus.comma_sel_out, DATA_SEL);
    check("data_cerr",  bus.code_err, 0);
    check("data_ferr",  bus.frame_err, 0);
    cyc('0, SELECT_COMMA_DATA, 1'b0, 1'b0);
    check("idle_valid", bus.valid_out, 0);
    check("idle_flit",  bus.flit_out, 40'h0123456789);
    send(rdp_flit, SELECT_COMMA_DATA);
    check("rdp_flit",   bus.flit_out, 40'h3CFF5AA500);
    check("rdp_cerr",   bus.code_err, 0);
    send(start_flit, SELECT_COMMA_1_FLIT);
    check("end_valid",  bus.valid_out, 1);
    check("end_sel",    bus.comma_sel_out, END_PACKET_SEL);
    check("end_pkt",    bus.pkt_active, 0);

    // ---- 3: data while IDLE
    send(enc_flit(40'hDEADBEEF00), SELECT_COMMA_DATA);
    check("oof_ferr",  bus.frame_err, 1);
    check("oof_valid", bus.valid_out, 0);
    check("oof_cnt",   bus.err_count, 1);
    check("oof_hold",  bus.flit_out, 40'h3CFF5AA500);
    cyc('0, SELECT_COMMA_DATA, 1'b0, 1'b0);
    check("oof_pulse", bus.frame_err, 0);

    // ---- 4: resend comma, malformed resend, wrong length select
    send(resend_flit, SELECT_COMMA_2_FLIT);
    check("rs_valid", bus.valid_out, 1);
    check("rs_sel",   bus.comma_sel_out, RESEND_PACKET0_SEL);
    check("rs_meta",  bus.meta_out, 8'h03);
    check("rs_ferr",  bus.frame_err, 0);
    check("rs_pkt",   bus.pkt_active, 0);
    send(resend_bad, SELECT_COMMA_2_FLIT);
    check("rsbad_ferr",  bus.frame_err, 1);
    check("rsbad_valid", bus.valid_out, 0);
    check("rsbad_cnt",   bus.err_count, 2);
    send(resend_flit, SELECT_COMMA_1_FLIT);
    check("lensel_ferr", bus.frame_err, 1);
    check("lensel_cnt",  bus.err_count, 3);
    check("lensel_pkt",  bus.pkt_active, 0);

    // ---- 5: code errors, saturation, clear
    send(start_flit, SELECT_COMMA_1_FLIT);
    check("s5_pkt", bus.pkt_active, 1);
    send(bad_flit, SELECT_COMMA_DATA);
    check("cerr_pulse", bus.code_err, 1);
    check("cerr_valid", bus.valid_out, 1);
    check("cerr_ferr",  bus.frame_err, 0);
    check("cerr_cnt",   bus.err_count, 4);
    for (int i = 0; i < 300; i++) send(bad_flit, SELECT_COMMA_DATA);
    check("sat_cnt", bus.err_count, 8'hFF);
    check("sat_pkt", bus.pkt_active, 1);
    cyc(bad_flit, SELECT_COMMA_DATA, 1'b1, 1'b1);
    check("clr_err_cnt", bus.err_count, 1);
    cyc('0, SELECT_COMMA_DATA, 1'b0, 1'b1);
    check("clr_cnt", bus.err_count, 0);

    // ---- 6: reset mid-packet
    send(enc_flit(40'hCAFEF00D42), SELECT_COMMA_DATA);
    check("pre_rst_pkt",  bus.pkt_active, 1);
    check("pre_rst_flit", bus.flit_out, 40'hCAFEF00D42);
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    check("arst_pkt",   bus.pkt_active, 0);
    check("arst_valid", bus.valid_out, 0);
    check("arst_sel",   bus.comma_sel_out, DATA_SEL);
    @(negedge CLK);
    nRST = 1'b1;
    send(enc_flit(40'h0011223344), SELECT_COMMA_DATA);
    check("post_rst_ferr",  bus.frame_err, 1);
    check("post_rst_valid", bus.valid_out, 0);
    check("post_rst_cnt",   bus.err_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
